// File: rtl/proc_ctrl_seq.sv
// Multicycle fetch/decode/execute control sequencer for the accumulator processor.
// Moore FSM driving datapath strobes, with a bounded memory-ready wait and sticky error.
module proc_ctrl_seq #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       z_flag,
    input  logic       mem_ready,
    output logic       ar_load,
    output logic       ar_src,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       ir_load,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ac_load,
    output logic [1:0] alu_op,
    output logic       busy,
    output logic       halted,
    output logic       err,
    output logic [3:0] state
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_FETCH_ADDR = 4'd1;
    localparam logic [3:0] S_FETCH_RD   = 4'd2;
    localparam logic [3:0] S_FETCH_IR   = 4'd3;
    localparam logic [3:0] S_DECODE     = 4'd4;
    localparam logic [3:0] S_OPND_ADDR  = 4'd5;
    localparam logic [3:0] S_OPND_RD    = 4'd6;
    localparam logic [3:0] S_EXEC       = 4'd7;
    localparam logic [3:0] S_OPND_WR    = 4'd8;
    localparam logic [3:0] S_JUMP       = 4'd9;
    localparam logic [3:0] S_HALT       = 4'd10;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDAC = 4'd1;
    localparam logic [3:0] OP_STAC = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_JZ   = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [7:0] r_wait_cnt;
    logic       r_err;
    logic       w_set_err;
    logic [1:0] r_alu_sel;
    logic       r_is_store;
    logic       w_mem_state;
    logic       w_timeout;

    assign w_mem_state = (r_state == S_FETCH_RD) || (r_state == S_OPND_RD) ||
                         (r_state == S_OPND_WR);
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == WAIT_MAX);

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        w_next    = r_state;
        w_set_err = 1'b0;
        case (r_state)
            S_IDLE:       if (start) w_next = S_FETCH_ADDR;
            S_FETCH_ADDR: w_next = S_FETCH_RD;
            S_FETCH_RD:   if (mem_ready) w_next = S_FETCH_IR;
            S_FETCH_IR:   w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOP:  w_next = S_FETCH_ADDR;
                    OP_LDAC, OP_STAC, OP_ADD, OP_SUB:
                             w_next = S_OPND_ADDR;
                    OP_JMP:  w_next = S_JUMP;
                    OP_JZ:   w_next = z_flag ? S_JUMP : S_FETCH_ADDR;
                    OP_HALT: w_next = S_HALT;
                    default: begin
                        w_next    = S_HALT;
                        w_set_err = 1'b1;
                    end
                endcase
            end
            S_OPND_ADDR:  w_next = r_is_store ? S_OPND_WR : S_OPND_RD;
            S_OPND_RD:    if (mem_ready) w_next = S_EXEC;
            S_EXEC:       w_next = S_FETCH_ADDR;
            S_OPND_WR:    if (mem_ready) w_next = S_FETCH_ADDR;
            S_JUMP:       w_next = S_FETCH_ADDR;
            S_HALT:       w_next = S_HALT;
            default: begin
                w_next    = S_HALT;
                w_set_err = 1'b1;
            end
        endcase
        // A stalled memory access overrides whatever the state would otherwise do.
        if (w_timeout) begin
            w_next    = S_HALT;
            w_set_err = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
            r_alu_sel  <= 2'b00;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_err) r_err <= 1'b1;
            if (w_mem_state && !mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + 8'd1;
            else                                         r_wait_cnt <= '0;
            // Capture the operation class once so later states are a pure decode of registers.
            if (r_state == S_DECODE) begin
                r_is_store <= (opcode == OP_STAC);
                case (opcode)
                    OP_ADD:  r_alu_sel <= 2'b01;
                    OP_SUB:  r_alu_sel <= 2'b10;
                    default: r_alu_sel <= 2'b00;
                endcase
            end
        end
    end

    always_comb begin
        ar_load = 1'b0;
        ar_src  = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        ir_load = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ac_load = 1'b0;
        alu_op  = 2'b00;
        halted  = 1'b0;
        case (r_state)
            S_FETCH_ADDR: ar_load = 1'b1;
            S_FETCH_RD:   mem_rd  = 1'b1;
            S_FETCH_IR: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            S_OPND_ADDR: begin
                ar_load = 1'b1;
                ar_src  = 1'b1;
            end
            S_OPND_RD:    mem_rd  = 1'b1;
            S_EXEC: begin
                ac_load = 1'b1;
                alu_op  = r_alu_sel;
            end
            S_OPND_WR:    mem_wr  = 1'b1;
            S_JUMP:       pc_load = 1'b1;
            S_HALT:       halted  = 1'b1;
            default: ;
        endcase
    end

    assign busy  = (r_state != S_IDLE) && (r_state != S_HALT);
    assign err   = r_err;
    assign state = r_state;

endmodule

// File: doc/proc_ctrl_seq.md
# proc_ctrl_seq

Multicycle control sequencer for the Phase 2 accumulator processor. It replaces the free-running control-word stepper with an opcode-driven fetch/decode/execute state machine. It drives the PC, AR, IR, AC, ALU and memory-strobe controls of the datapath, waits on a memory ready handshake, and halts on a HALT opcode, an illegal opcode or a memory timeout.

## Interface
- MEM_WAIT_MAX, default 15: maximum consecutive cycles a memory state may wait with mem_ready low. Legal range is 1..255.
- clk  in  1  system clock; all state changes occur on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  level; leaves IDLE when high.
- opcode  in  4  IR opcode field; valid from DECODE until the next FETCH_IR.
- z_flag  in  1  accumulator-zero flag from the datapath.
- mem_ready  in  1  memory completion for the current mem_rd/mem_wr.
- ar_load  out  1  load AR.
- ar_src  out  1  0 = AR from PC, 1 = AR from IR operand.
- pc_inc  out  1  increment PC.
- pc_load  out  1  PC from IR operand.
- ir_load  out  1  load IR from memory data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- ac_load  out  1  load AC from ALU.
- alu_op  out  2  00 pass, 01 add, 10 sub, 11 unused.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- err  out  1  sticky error; cleared only by rst.
- state  out  4  current state encoding, for debug.

## Operation
- Opcodes: 0 NOP, 1 LDAC, 2 STAC, 3 ADD, 4 SUB, 5 JMP, 6 JZ, 7 HALT, 8..15 illegal.
- Moore machine: every output is a pure decode of the state register (err is the exception, a separate flop). Any output not listed for a state is 0.
- IDLE (0): if start then FETCH_ADDR.
- FETCH_ADDR (1): ar_load=1, ar_src=0; next FETCH_RD.
- FETCH_RD (2): mem_rd=1; stay until mem_ready, then FETCH_IR.
- FETCH_IR (3): ir_load=1, pc_inc=1; next DECODE.
- DECODE (4), no outputs; branch on opcode:
  - NOP goes to FETCH_ADDR.
  - LDAC, ADD, SUB and STAC go to OPND_ADDR.
  - JMP goes to JUMP.
  - JZ goes to JUMP if z_flag is high, else FETCH_ADDR.
  - HALT goes to HALT.
  - An illegal opcode sets err and goes to HALT.
- OPND_ADDR (5): ar_load=1, ar_src=1; next OPND_WR if STAC, else OPND_RD.
- OPND_RD (6): mem_rd=1; stay until mem_ready, then EXEC.
- EXEC (7): ac_load=1; alu_op = 00 for LDAC, 01 for ADD, 10 for SUB; next FETCH_ADDR.
- OPND_WR (8): mem_wr=1; stay until mem_ready, then FETCH_ADDR.
- JUMP (9): pc_load=1; next FETCH_ADDR.
- HALT (10): halted=1; absorbing, exits only on rst; start is ignored.
- Encodings 11..15 are unreachable; if entered, go to HALT and set err.
- Wait counter (8 bits):
  - Cleared on entry to any memory state (2, 6, 8) and whenever mem_ready is high.
  - Increments each cycle in a memory state while mem_ready is low.
  - When the counter equals MEM_WAIT_MAX with mem_ready still low: set err and go to HALT. Strobes drop the next cycle.
- mem_ready is sampled only in memory states; it is ignored elsewhere.

## Timing
- Reset (asynchronous, immediate): state=IDLE, counter=0, err=0. All outputs are 0, including busy and halted.
- rst asserted mid-instruction aborts it immediately; strobes drop in the same cycle, with no completion.
- A memory state lasts at least 1 cycle. mem_ready high in the first cycle of the strobe completes the access in that cycle (zero-wait).
- Cycles per instruction with zero-wait memory; each wait cycle adds 1:
  - NOP: 4.
  - JZ not taken: 4.
  - JMP: 5.
  - JZ taken: 5.
  - STAC: 6.
  - LDAC, ADD, SUB: 7.
- Timeout: with mem_ready held low, the strobe stays high for MEM_WAIT_MAX+1 cycles. HALT is entered on the following edge.
- z_flag is sampled only in DECODE, one cycle after ir_load, which reflects the AC from the previous instruction.
- start held high after reset: FETCH_ADDR on the first edge after rst deasserts.

## Test plan
- Reset mid-fetch: assert rst while in FETCH_RD with mem_rd=1 -> mem_rd=0, state=0 and err=0 asynchronously; after release with start=1, state=1 on the next edge.
- Zero-wait program NOP, LDAC, ADD, STAC, HALT with mem_ready tied high -> instruction lengths 4/7/7/6 cycles; alu_op 00 then 01 in EXEC; halted=1 after cycle 28, busy=0 there.
- JZ both ways: z_flag=1 -> pc_load pulses for 1 cycle, 5 cycles total; z_flag=0 -> no pc_load, 4 cycles.
- Wait states: mem_ready low for 3 cycles in OPND_RD -> mem_rd high for 4 cycles, LDAC takes 10 cycles, err=0.
- Timeout with MEM_WAIT_MAX=4: mem_ready stuck low in FETCH_RD -> mem_rd high 5 cycles, then err=1, halted=1, state=10; start ignored thereafter.
- Illegal opcode 12 in DECODE -> err=1, state=10 next cycle, no strobes asserted.
